rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
Parametrised N-channel successor to the combinational 2:1 mux. It arbitrates between NUM_CH valid/ready input channels, with round-robin priority by default. The winning channel's data is captured into a single registered output stage with a valid/ready handshake. It is used wherever several pipeline sources share one downstream port, for example fetch and load/store requests sharing a memory port.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- NUM_CH, 4, number of input channels (>=2).
- CH_W, $clog2(NUM_CH), width of the channel index. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  NUM_CH  bit i: channel i presents data.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  bit i: channel i's data is accepted this cycle.
- out_valid  output  1  the output register holds data.
- out_data  output  WIDTH  registered data of the granted channel.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_ready  input  1  the downstream consumer accepts out_data this cycle.

Behaviour:
- Reset: clock and reset use one clock; reset is synchronous and active-high. While rst=1 at a clock edge, the following values are loaded:
  - out_valid=0
  - out_data=0
  - out_ch=0
  - priority pointer ptr=0
- in_ready is combinational, so in_ready=0 while out_valid=0 only when all in_valid are 0.
- load = !out_valid || out_ready. The output register can accept a new word this cycle.
- Grant selection:
  - Search channels ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1.
  - The first channel with in_valid=1 wins (gnt, one-hot or all-zero).
  - Index arithmetic is modulo NUM_CH; this must be correct for non-power-of-two NUM_CH.
- in_ready = gnt & {NUM_CH{load}}. At most one bit of in_ready is high. in_ready never depends on in_data.
- Transfer on channel k: in_valid[k] && in_ready[k]. At the next edge:
  - out_data <= in_data[k]
  - out_ch <= k
  - out_valid <= 1
  - ptr <= (k+1) mod NUM_CH
- Drain without refill: out_valid && out_ready with no input transfer sets out_valid <= 0. out_data and out_ch hold their values.
- Simultaneous drain and refill: the new word is loaded in the same cycle. Full throughput is one word per cycle.
- Stall: out_valid && !out_ready means all in_ready=0, and out_data, out_ch and ptr are held stable.
- ptr changes only on a transfer. Idle cycles do not rotate priority.
- Latency: one cycle from input transfer to out_valid.
- Upstream convention: inputs must not retract in_valid before their transfer. The block does not check this.
- Reset mid-transfer: any pending word is discarded. No in_ready is asserted during the reset cycle.

Optional Feature:
- Macro: RR_ARB_MUX_FIXED_PRIO_EN.
- When defined:
  - The search always starts at channel 0, so the lowest index wins.
  - The ptr register is not implemented.
  - All other behaviour is unchanged.
- When undefined: round-robin arbitration as described above.

Test Plan:
1. Reset, single channel (WIDTH=5, NUM_CH=4):
   - Hold rst=1 for 2 cycles: out_valid=0, out_data=0, out_ch=0.
   - Release reset; in_valid=4'b0001, in_data[0]=5'h15, out_ready=1.
   - Required: in_ready=4'b0001; next cycle out_valid=1, out_data=5'h15, out_ch=0.
2. Round-robin fairness:
   - Drive in_valid=4'b1111 continuously with data 5'h01, 5'h02, 5'h03, 5'h04 on channels 0-3, out_ready=1.
   - Required: out_ch sequence 0,1,2,3,0,... with a back-to-back word every cycle.
3. Backpressure:
   - With out_valid=1, out_data=5'h0A, drive out_ready=0 for 3 cycles while in_valid=4'b0110.
   - Required: in_ready=0, and out_data/out_ch stable.
   - Raise out_ready: channel 1 transfers, then channel 2 transfers.
4. Pointer skip:
   - Set ptr=2 by granting channel 1 first, then drive in_valid=4'b0011.
   - Required: channel 0 is granted, ptr wraps past 3, and next ptr=1.
5. Fixed-priority build, with RR_ARB_MUX_FIXED_PRIO_EN defined:
   - Drive in_valid=4'b1111 for 4 cycles.
   - Required: out_ch=0 on every cycle; channels 1-3 see in_ready=0.
6. Mid-operation reset:
   - Assert rst=1 while out_valid=1 and in_valid=4'b1000.
   - Required: next cycle out_valid=0 and in_ready=0 during reset.
   - After release, channel 3 is granted first, from ptr=0 scanning 0→3.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: arbitrates NUM_CH valid/ready channels into one registered output stage.
// Round-robin by default; define RR_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*WIDTH-1:0]  in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   start;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W:0]     idx;
  logic              found;
  logic              load;
  logic              xfer;
  logic [WIDTH-1:0]  sel_data;
  logic [CH_W-1:0]   sel_ch;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [CH_W-1:0] ptr_q, ptr_d;

  assign start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Wrap by subtraction so the search order is correct for non-power-of-two NUM_CH.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, start} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (!found && in_valid[idx[CH_W-1:0]]) begin
        gnt[idx[CH_W-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_ch   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) begin
        sel_data = in_data[c*WIDTH +: WIDTH];
        sel_ch   = CH_W'(c);
      end
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign in_ready = rst ? '0 : (gnt & {NUM_CH{load}});
  assign xfer     = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = sel_ch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
